// File: rtl/uc_microc.sv
// Control unit for the single-cycle microcontroller: opcode decode plus WAIT/HALT sequencing and PC hold.
// Optional UC_TRAP_EN: undefined 11xxxx opcodes halt the core and raise trap.
module uc_microc #(
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter int unsigned WAIT_W      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] Op,
    output logic       pc_en,
    output logic       halted,
    output logic       trap
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;
    logic              w_trap_set;

    // Decode and sequencing; outputs stay at their idle values while reset is held.
    always_comb begin
        s_inc       = 1'b0;
        s_inm       = 1'b0;
        we3         = 1'b0;
        wez         = 1'b0;
        Op          = 3'b000;
        pc_en       = 1'b1;
        halted      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_trap_set  = 1'b0;
        if (reset) begin
            case (r_state)
                S_RUN: begin
                    if (Opcode == HALT_OPCODE) begin
                        pc_en       = 1'b0;
                        w_state_nxt = S_HALT;
                    end else begin
                        casez (Opcode)
                            6'b0?????: begin
                                Op  = Opcode[4:2];
                                we3 = 1'b1;
                                wez = 1'b1;
                            end
                            6'b100???: begin
                                s_inm = 1'b1;
                                we3   = 1'b1;
                            end
                            6'b101???: begin
                                pc_en       = 1'b0;
                                w_cnt_nxt   = WAIT_W'(Opcode[2:0]);
                                w_state_nxt = S_WAIT;
                            end
                            6'b110000: s_inc = 1'b1;
                            6'b110001: s_inc = z;
                            6'b110010: s_inc = ~z;
                            6'b110011: ;
                            default: begin
`ifdef UC_TRAP_EN
                                pc_en       = 1'b0;
                                w_state_nxt = S_HALT;
                                w_trap_set  = 1'b1;
`endif
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        pc_en     = 1'b0;
                        w_cnt_nxt = r_cnt - WAIT_W'(1);
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_HALT: begin
                    pc_en  = 1'b0;
                    halted = 1'b1;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef UC_TRAP_EN
    logic r_trap;

    // Sticky cause flag; only reset leaves HALT, so it also clears here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trap <= 1'b0;
        end else if (w_trap_set) begin
            r_trap <= 1'b1;
        end
    end

    assign trap = r_trap & (r_state == S_HALT);
`else
    assign trap = 1'b0 & w_trap_set;
`endif

endmodule

// File: tb/tb_uc_microc.sv
// Self-checking bench for uc_microc: instruction-level model compared every cycle plus directed literal checks.
module tb_uc_microc;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       z;
    logic       s_inc, s_inm, we3, wez, pc_en, halted, trap;
    logic [2:0] Op;

    int checks = 0;
    int errors = 0;

    uc_microc dut (
        .clk    (clk),
        .reset  (reset),
        .Opcode (Opcode),
        .z      (z),
        .s_inc  (s_inc),
        .s_inm  (s_inm),
        .we3    (we3),
        .wez    (wez),
        .Op     (Op),
        .pc_en  (pc_en),
        .halted (halted),
        .trap   (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Instruction-level model: m_left counts cycles still owed to the current WAIT instruction.
    logic m_halt, m_trap;
    int   m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_halt <= 1'b0;
            m_trap <= 1'b0;
            m_left <= 0;
        end else if (m_halt) begin
            m_halt <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (Opcode == 6'b111111) begin
            m_halt <= 1'b1;
        end else if (Opcode[5:3] == 3'b101) begin
            m_left <= int'(Opcode[2:0]) + 1;
        end else if (Opcode[5:4] == 2'b11 && Opcode[3:2] != 2'b00) begin
`ifdef UC_TRAP_EN
            m_halt <= 1'b1;
            m_trap <= 1'b1;
`endif
        end
    end

    function automatic logic [9:0] expect_out(input logic [5:0] o, input logic zz, input logic rn,
                                              input logic mh, input logic mt, input int ml);
        logic si, sm, w3, wz, pe, hl, tr;
        logic [2:0] op;
        si = 0; sm = 0; w3 = 0; wz = 0; op = 3'b000; pe = 1; hl = 0; tr = 0;
        if (!rn) begin
        end else if (mh) begin
            pe = 0; hl = 1; tr = mt;
        end else if (ml > 0) begin
            pe = (ml == 1);
        end else if (o == 6'b111111) begin
            pe = 0;
        end else if (o[5] == 1'b0) begin
            op = o[4:2]; w3 = 1; wz = 1;
        end else if (o[5:3] == 3'b100) begin
            sm = 1; w3 = 1;
        end else if (o[5:3] == 3'b101) begin
            pe = 0;
        end else if (o == 6'b110000) begin
            si = 1;
        end else if (o == 6'b110001) begin
            si = zz;
        end else if (o == 6'b110010) begin
            si = ~zz;
        end else if (o == 6'b110011) begin
        end else begin
`ifdef UC_TRAP_EN
            pe = 0;
`endif
        end
        return {si, sm, w3, wz, op, pe, hl, tr};
    endfunction

    always @(negedge clk) begin
        chk("cycle_model", {22'd0, s_inc, s_inm, we3, wez, Op, pc_en, halted, trap},
            {22'd0, expect_out(Opcode, z, reset, m_halt, m_trap, m_left)});
    end

    task automatic step(input logic [5:0] o, input logic zz);
        @(posedge clk);
        #1;
        Opcode = o;
        z      = zz;
        #2;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        Opcode = 6'b000000;
        z      = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_pc_en", 32'(pc_en), 32'd1);
        chk("reset_we3", 32'(we3), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset mid-WAIT with cnt=5
        step(6'b101101, 1'b0);
        chk("wait5_first_pc_en", 32'(pc_en), 32'd0);
        step(6'b101101, 1'b0);
        chk("wait5_held_pc_en", 32'(pc_en), 32'd0);
        reset = 1'b0;
        #1;
        chk("midwait_reset_pc_en", 32'(pc_en), 32'd1);
        chk("midwait_reset_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        Opcode = 6'b000100;
        #2;
        chk("after_reset_alu", 32'({we3, wez, Op}), 32'b11001);

        step(6'b100000, 1'b0);
        chk("li_outs", 32'({s_inc, s_inm, we3, wez, Op, pc_en}), 32'b0110_0001);
        step(6'b011100, 1'b1);
        chk("alu_op7", 32'({we3, wez, Op, s_inm}), 32'b1111_10);
        step(6'b110001, 1'b1);
        chk("jz_z1", 32'({s_inc, we3, wez}), 32'b100);
        step(6'b110001, 1'b0);
        chk("jz_z0", 32'({s_inc, we3, wez}), 32'b000);
        step(6'b110010, 1'b1);
        chk("jnz_z1", 32'({s_inc, we3, wez}), 32'b000);
        step(6'b110010, 1'b0);
        chk("jnz_z0", 32'({s_inc, we3, wez}), 32'b100);
        step(6'b110000, 1'b0);
        chk("j_taken", 32'(s_inc), 32'd1);
        step(6'b110011, 1'b1);
        chk("nop_outs", 32'({s_inc, we3, wez, pc_en}), 32'b0001);

        // WAIT 2: pc_en 0,0,0,1 with z toggling underneath
        for (int i = 0; i < 4; i++) begin
            step(6'b101010, 1'(i));
            chk("wait2_pc_en", 32'(pc_en), (i == 3) ? 32'd1 : 32'd0);
            chk("wait2_writes", 32'({we3, wez}), 32'd0);
        end
        step(6'b000000, 1'b0);
        chk("after_wait2_run", 32'({we3, wez}), 32'b11);

        for (int i = 0; i < 2; i++) begin
            step(6'b101000, 1'b1);
            chk("wait0_pc_en", 32'(pc_en), (i == 1) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 9; i++) begin
            step(6'b101111, 1'(i));
            chk("wait7_pc_en", 32'(pc_en), (i == 8) ? 32'd1 : 32'd0);
        end

        // Undefined 11xxxx opcode
        step(6'b111000, 1'b0);
`ifdef UC_TRAP_EN
        chk("illegal_enter_pc_en", 32'(pc_en), 32'd0);
        step(6'b000100, 1'b1);
        chk("illegal_halted_trap", 32'({halted, trap, pc_en, we3}), 32'b1100);
        pulse_reset();
        #2;
        chk("trap_cleared", 32'({halted, trap}), 32'b00);
`else
        chk("illegal_as_nop", 32'({pc_en, s_inc, we3, wez, halted, trap}), 32'b100000);
        step(6'b000100, 1'b1);
        chk("illegal_still_running", 32'({we3, halted}), 32'b10);
`endif

        // HALT holds regardless of Opcode and z
        step(6'b111111, 1'b0);
        chk("halt_enter", 32'({pc_en, halted}), 32'b00);
        step(6'b000100, 1'b1);
        chk("halt_c1", 32'({pc_en, halted, trap, we3, wez, s_inc}), 32'b010000);
        step(6'b110000, 1'b0);
        chk("halt_c2", 32'({pc_en, halted, trap, we3, wez, s_inc}), 32'b010000);
        step(6'b101010, 1'b1);
        chk("halt_c3", 32'({pc_en, halted, trap, we3, wez, s_inc}), 32'b010000);
        pulse_reset();
        Opcode = 6'b110011;
        #2;
        chk("halt_cleared", 32'({halted, pc_en}), 32'b01);
        step(6'b110011, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
